// File: rtl/fridge_status_tx_pkg.sv
// Shared types and widths for the fridge status transmitter.
// Holds the frame FSM states and the settings word layout.
package fridge_pkg;

    localparam int DATA_W  = 27;
    localparam int FRAME_W = 30;
    localparam int TEMP_W  = 5;
    localparam int CAP_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Settings word, fgt[0] in bit 0 and ice in the top bit.
    function automatic logic [DATA_W-1:0] pack_word(
        input logic             ice,
        input logic [CAP_W-1:0]  frc,
        input logic [CAP_W-1:0]  fgc,
        input logic [TEMP_W-1:0] frt,
        input logic [TEMP_W-1:0] fgt
    );
        return {ice, frc, fgc, frt, fgt};
    endfunction

endpackage

// File: rtl/fridge_status_tx_if.sv
// Settings/request bundle and serial-line outputs of the status
// transmitter, seen from the controller (master) and block (slave).
interface fridge_status_tx_if;
    import fridge_pkg::*;

    logic              i;
    logic              req;
    logic [TEMP_W-1:0] fgt;
    logic [TEMP_W-1:0] frt;
    logic [CAP_W-1:0]  fgc;
    logic [CAP_W-1:0]  frc;
    logic              ice;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        output i, req, fgt, frt, fgc, frc, ice,
        input  tx, busy, done
    );

    modport slave (
        input  i, req, fgt, frt, fgc, frc, ice,
        output tx, busy, done
    );

endinterface

// File: rtl/fridge_status_tx_baud.sv
// Bit-period down-counter for the status transmitter.
// Ticks once per serial bit; clearing realigns it to a new bit.
module fridge_baud_counter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

    logic [7:0] r_cnt;

    // Count down to zero, then reload; clear restarts a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || r_cnt == 8'd0) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_tick = (r_cnt == 8'd0);

endmodule

// File: rtl/fridge_status_tx.sv
// Serial status transmitter: snapshots the settings on request and
// sends start, 27 data bits LSB first, even parity and stop.
module fridge_status_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    fridge_status_tx_if.slave   bus
);
    import fridge_pkg::*;

    localparam logic [4:0] LAST_DATA = 5'(FRAME_W - 3);

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic [4:0]        r_idx;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    logic w_tick;
    logic w_accept;
    logic w_abort;
    logic w_clr;

    assign w_accept = (r_state == IDLE) && bus.i && bus.req;
    assign w_abort  = (r_state != IDLE) && !bus.i;
    assign w_clr    = w_accept || w_abort;

    fridge_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    // Frame FSM; r_idx is the frame bit currently on the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= IDLE;
                r_shift <= '0;
                r_par   <= 1'b0;
                r_idx   <= '0;
                r_tx    <= 1'b1;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_state <= START;
                            r_shift <= pack_word(bus.ice, bus.frc,
                                                 bus.fgc, bus.frt,
                                                 bus.fgt);
                            r_par   <= 1'b0;
                            r_idx   <= '0;
                            r_tx    <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                    START: begin
                        if (w_tick) begin
                            r_state <= DATA;
                            r_tx    <= r_shift[0];
                            r_par   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_idx   <= 5'd1;
                        end
                    end
                    DATA: begin
                        if (w_tick) begin
                            r_idx <= r_idx + 5'd1;
                            if (r_idx == LAST_DATA) begin
                                r_state <= PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_tx    <= r_shift[0];
                                r_par   <= r_par ^ r_shift[0];
                                r_shift <= r_shift >> 1;
                            end
                        end
                    end
                    PARITY: begin
                        if (w_tick) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                            r_idx   <= r_idx + 5'd1;
                        end
                    end
                    STOP: begin
                        if (w_tick) begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_idx   <= '0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tx   = r_tx;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
